wall_probe: RTL and testbench

Sequential collision checker that queries the maze wall map on behalf of a moving sprite. Given a sprite's top-left position and a requested direction, it computes the one-step candidate position. It then drives the leading-edge pixel coordinates of that candidate, one per cycle, into a dedicated wall-map instance and samples its combinational `wall_on` reply. It returns blocked/allowed and the resulting position, and sits between the Pac-Man/ghost motion logic and the wall map.

---
 rtl/wall_probe.sv | 147 ++++++++++++++
 tb/tb_wall_probe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wall_probe.sv
// Sprite collision checker: walks the leading edge of a one-step candidate box through the wall map.
// Optional macro WALL_PROBE_EARLY_EXIT_EN ends the scan on the first wall hit.
module wall_probe #(
    parameter int SPRITE_W = 13,
    parameter int STEP     = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic [1:0]  req_dir,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    output logic [10:0] ProbeX,
    output logic [10:0] ProbeY,
    input  logic        wall_on,
    output logic        busy,
    output logic        done,
    output logic        blocked,
    output logic [10:0] new_x,
    output logic [10:0] new_y
);

    localparam logic [11:0] STEP12 = 12'(STEP);
    localparam logic [11:0] SPAN12 = 12'(SPRITE_W - 1);
    localparam logic [5:0]  LAST_K = 6'(SPRITE_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_acc;
    logic        r_along_y;
    logic [10:0] r_cx;
    logic [10:0] r_cy;
    logic [10:0] r_ox;
    logic [10:0] r_oy;

    logic [11:0] w_px;
    logic [11:0] w_py;
    logic [11:0] w_cx;
    logic [11:0] w_cy;
    logic [11:0] w_ex;
    logic [11:0] w_ey;
    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic        w_oor;
    logic        w_acc_n;
    logic        w_stop;

    // Candidate box, its far corner along the probed edge, and probe point 0, all with a spare
    // 12th bit so that a borrow or an overflow past 11'h7FF shows up as bit 11.
    always_comb begin
        w_px = {1'b0, pos_x};
        w_py = {1'b0, pos_y};
        w_cx = w_px;
        w_cy = w_py;
        case (req_dir)
            2'b00:   w_cy = w_py - STEP12;
            2'b01:   w_cy = w_py + STEP12;
            2'b10:   w_cx = w_px - STEP12;
            default: w_cx = w_px + STEP12;
        endcase
        w_ex  = (req_dir == 2'b10) ? w_cx : w_cx + SPAN12;
        w_ey  = (req_dir == 2'b00) ? w_cy : w_cy + SPAN12;
        w_sx  = (req_dir == 2'b11) ? w_ex[10:0] : w_cx[10:0];
        w_sy  = (req_dir == 2'b01) ? w_ey[10:0] : w_cy[10:0];
        w_oor = w_cx[11] | w_cy[11] | w_ex[11] | w_ey[11];
    end

    assign w_acc_n = r_acc | wall_on;

`ifdef WALL_PROBE_EARLY_EXIT_EN
    assign w_stop = (r_cnt == LAST_K) || wall_on;
`else
    assign w_stop = (r_cnt == LAST_K);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_acc     <= 1'b0;
            r_along_y <= 1'b0;
            r_cx      <= 11'd0;
            r_cy      <= 11'd0;
            r_ox      <= 11'd0;
            r_oy      <= 11'd0;
            ProbeX    <= 11'd0;
            ProbeY    <= 11'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            blocked   <= 1'b0;
            new_x     <= 11'd0;
            new_y     <= 11'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_ox      <= pos_x;
                        r_oy      <= pos_y;
                        r_cx      <= w_cx[10:0];
                        r_cy      <= w_cy[10:0];
                        r_along_y <= req_dir[1];
                        r_cnt     <= 6'd0;
                        r_acc     <= 1'b0;
                        busy      <= 1'b1;
                        if (w_oor) begin
                            r_state <= S_DONE;
                            done    <= 1'b1;
                            blocked <= 1'b1;
                            new_x   <= pos_x;
                            new_y   <= pos_y;
                        end else begin
                            r_state <= S_PROBE;
                            ProbeX  <= w_sx;
                            ProbeY  <= w_sy;
                        end
                    end
                end
                S_PROBE: begin
                    r_acc <= w_acc_n;
                    if (w_stop) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        blocked <= w_acc_n;
                        new_x   <= w_acc_n ? r_ox : r_cx;
                        new_y   <= w_acc_n ? r_oy : r_cy;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_along_y) begin
                            ProbeY <= ProbeY + 11'd1;
                        end else begin
                            ProbeX <= ProbeX + 11'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_probe.sv
// Bench for wall_probe: a timestamped transaction model predicts every output each cycle,
// and directed requests pin latency and results with hand-worked numbers.
module tb_wall_probe;

    localparam int W    = 13;
    localparam int STEP = 1;
`ifdef WALL_PROBE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  req_dir = 2'b00;
    logic [10:0] pos_x = 11'd0;
    logic [10:0] pos_y = 11'd0;
    logic [10:0] ProbeX, ProbeY, new_x, new_y;
    logic        wall_on, busy, done, blocked;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    wall_probe #(.SPRITE_W(W), .STEP(STEP)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_dir(req_dir),
        .pos_x(pos_x), .pos_y(pos_y), .ProbeX(ProbeX), .ProbeY(ProbeY),
        .wall_on(wall_on), .busy(busy), .done(done), .blocked(blocked),
        .new_x(new_x), .new_y(new_y)
    );

    always #5 Clk = ~Clk;

    // Maze: everything at y<=50 is the top boundary, plus one block x 191..200, y 80..100.
    function automatic bit wall_at(input int x, input int y);
        return (y <= 50) || (x >= 191 && x <= 200 && y >= 80 && y <= 100);
    endfunction

    assign wall_on = wall_at(int'(ProbeX), int'(ProbeY));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: on acceptance it works out the probe list, result and done cycle.
    int m_n = -100, m_done = -10, m_np = 0;
    int m_ptx[64], m_pty[64];
    bit m_blk;
    int m_nx, m_ny;
    logic        e_busy = 0, e_done = 0, e_blk = 0;
    logic [10:0] e_px = 0, e_py = 0, e_nx = 0, e_ny = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            m_n = -100; m_done = -10; m_np = 0;
            e_busy = 0; e_done = 0; e_blk = 0;
            e_px = 0; e_py = 0; e_nx = 0; e_ny = 0;
            cyc = cyc + 1;
        end else begin
            if (cyc > m_done && req) begin
                int cx, cy, px, py;
                bit oor, hit;
                m_n = cyc;
                cx = int'(pos_x);
                cy = int'(pos_y);
                case (req_dir)
                    2'b00: cy = cy - STEP;
                    2'b01: cy = cy + STEP;
                    2'b10: cx = cx - STEP;
                    default: cx = cx + STEP;
                endcase
                oor = (cx < 0) || (cy < 0);
                for (int k = 0; k < W; k++) begin
                    case (req_dir)
                        2'b00: begin px = cx + k; py = cy; end
                        2'b01: begin px = cx + k; py = cy + W - 1; end
                        2'b10: begin px = cx; py = cy + k; end
                        default: begin px = cx + W - 1; py = cy + k; end
                    endcase
                    if (px > 2047 || py > 2047) oor = 1'b1;
                    m_ptx[k] = px;
                    m_pty[k] = py;
                end
                m_np = 0;
                hit = 1'b0;
                if (!oor) begin
                    for (int k = 0; k < W; k++) begin
                        if (!(EE && hit)) begin
                            m_np = k + 1;
                            if (wall_at(m_ptx[k], m_pty[k])) hit = 1'b1;
                        end
                    end
                end
                m_blk  = oor || hit;
                m_nx   = m_blk ? int'(pos_x) : cx;
                m_ny   = m_blk ? int'(pos_y) : cy;
                m_done = m_n + m_np + 1;
            end
            cyc = cyc + 1;
            e_busy = (cyc >= m_n + 1) && (cyc <= m_done);
            e_done = (cyc == m_done);
            if (cyc >= m_n + 1 && cyc <= m_n + m_np) begin
                e_px = 11'(m_ptx[cyc - m_n - 1]);
                e_py = 11'(m_pty[cyc - m_n - 1]);
            end
            if (e_done) begin
                e_blk = m_blk;
                e_nx  = 11'(m_nx);
                e_ny  = 11'(m_ny);
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("ctl", {30'd0, busy, done}, {30'd0, e_busy, e_done});
            chk("probe", {10'd0, ProbeX, ProbeY}, {10'd0, e_px, e_py});
            chk("result", {9'd0, blocked, new_x, new_y}, {9'd0, e_blk, e_nx, e_ny});
        end
    end

    task automatic do_req(input int x, input int y, input logic [1:0] d, input int exp_lat,
                          input bit exp_blk, input int exp_nx, input int exp_ny, input bit disturb);
        int n, lat;
        req = 1'b1; req_dir = d; pos_x = 11'(x); pos_y = 11'(y);
        n = cyc;
        @(negedge Clk);
        req = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                lat = cyc - n;
                break;
            end
            if (disturb) begin
                if (cyc - n == 2) begin
                    req = 1'b1; req_dir = 2'b00; pos_x = 11'd600; pos_y = 11'd600;
                end else if (cyc - n == 3) begin
                    req = 1'b0;
                end else if (cyc - n == 6) begin
                    pos_x = 11'd5; pos_y = 11'd1000; req_dir = 2'b01;
                end
            end
            @(negedge Clk);
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("blocked", {31'd0, blocked}, {31'd0, exp_blk});
        chk("new_xy", {10'd0, new_x, new_y}, {10'd0, 11'(exp_nx), 11'(exp_ny)});
        @(negedge Clk);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        bit saw_done;
        int lat_hit0 = EE ? 2 : 14;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        chk("reset_state", {8'd0, busy, done, blocked, ProbeX, new_x[10:0]}, 32'd0);
        chk("reset_state_y", {10'd0, ProbeY, new_y}, 32'd0);
        chk_en = 1'b1;
        @(negedge Clk);

        do_req(170, 60, 2'b11, 14, 1'b0, 171, 60, 1'b0);
        do_req(170, 51, 2'b00, lat_hit0, 1'b1, 170, 51, 1'b0);
        do_req(178, 80, 2'b11, lat_hit0, 1'b1, 178, 80, 1'b0);
        do_req(177, 80, 2'b11, 14, 1'b0, 178, 80, 1'b0);
        do_req(0, 0, 2'b00, 1, 1'b1, 0, 0, 1'b0);
        chk("oor_probe_hold", {10'd0, ProbeX, ProbeY}, {10'd0, 11'd190, 11'd92});
        do_req(300, 300, 2'b01, 14, 1'b0, 300, 301, 1'b0);
        do_req(201, 85, 2'b10, lat_hit0, 1'b1, 201, 85, 1'b0);
        do_req(202, 85, 2'b10, 14, 1'b0, 201, 85, 1'b0);
        do_req(2035, 500, 2'b11, 1, 1'b1, 2035, 500, 1'b0);
        do_req(2034, 500, 2'b11, 14, 1'b0, 2035, 500, 1'b0);
        chk("edge_probe_x", {21'd0, ProbeX}, 32'd2047);
        do_req(500, 2035, 2'b01, 1, 1'b1, 500, 2035, 1'b0);
        do_req(201, 70, 2'b10, EE ? 12 : 14, 1'b1, 201, 70, 1'b0);
        do_req(170, 60, 2'b11, 14, 1'b0, 171, 60, 1'b1);

        req = 1'b1; req_dir = 2'b01; pos_x = 11'd300; pos_y = 11'd300;
        n = cyc;
        saw_done = 1'b0;
        @(negedge Clk);
        req = 1'b0;
        while (cyc < n + 5) begin
            if (done) saw_done = 1'b1;
            @(negedge Clk);
        end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        if (done) saw_done = 1'b1;
        chk("rst_abort_out", {8'd0, busy, done, blocked, ProbeX, new_x}, 32'd0);
        chk("rst_abort_y", {10'd0, ProbeY, new_y}, 32'd0);
        chk("rst_no_done", {31'd0, saw_done}, 32'd0);
        @(negedge Clk);
        do_req(300, 300, 2'b01, 14, 1'b0, 300, 301, 1'b0);

        repeat (3) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
